tour_cmd_seq: RTL

TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

---
 rtl/tour_cmd_seq_if.sv | 32 +++
 rtl/tour_cmd_seq.sv | 122 ++++++++++++
 2 files changed

// File: rtl/tour_cmd_seq_if.sv
// Bundle of signals between the knight-tour command sequencer, the tour
// solver, the UART wrapper and the motion command processor.
//   slave  : sequencer view (tour_start/move/uart/ack in, cmd/resp out)
//   master : environment view (drives the sequencer inputs)
interface tour_cmd_seq_if;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned MOVE_W = 8;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned RESP_W = 8;

  logic              tour_start;
  logic [MOVE_W-1:0] move;
  logic [IDX_W-1:0]  mv_indx;
  logic [CMD_W-1:0]  uart_cmd;
  logic              uart_cmd_rdy;
  logic              clr_uart_rdy;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              send_resp;
  logic [RESP_W-1:0] resp;

  modport slave (
    input  tour_start, move, uart_cmd, uart_cmd_rdy, clr_cmd_rdy, send_resp,
    output mv_indx, clr_uart_rdy, cmd, cmd_rdy, resp
  );

  modport master (
    output tour_start, move, uart_cmd, uart_cmd_rdy, clr_cmd_rdy, send_resp,
    input  mv_indx, clr_uart_rdy, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_cmd_seq.sv
// Knight-tour command sequencer. In IDLE the UART command path is passed
// straight through to the motion command processor. On tour_start it plays
// back 24 knight moves, each as a vertical leg (opcode 4) followed by a
// horizontal leg (opcode 5), waiting for the processor's send_resp between
// legs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : tour_cmd_seq_if.slave (tour/uart/cmd handshakes, resp)
module tour_cmd_seq (
  input  logic           clk,
  input  logic           rst_n,
  tour_cmd_seq_if.slave  bus
);
  localparam int unsigned CMD_W    = 16;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned RESP_W   = 8;
  localparam int unsigned LAST_IDX = 23;

  localparam logic [3:0]        OP_MOVE    = 4'h4;
  localparam logic [3:0]        OP_FANFARE = 4'h5;
  localparam logic [7:0]        HDG_N      = 8'h00;
  localparam logic [7:0]        HDG_W      = 8'h3F;
  localparam logic [7:0]        HDG_S      = 8'h7F;
  localparam logic [7:0]        HDG_E      = 8'hBF;
  localparam logic [RESP_W-1:0] RESP_DONE  = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_LEG   = 8'h5A;

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] mv_indx_q, mv_indx_nxt;
  logic [2:0]       v_sq, h_sq;
  logic             v_north, h_east;
  logic [CMD_W-1:0] vert_cmd, horz_cmd;
  logic             last_move;

  // Move decode: lowest set bit wins; leg lengths and directions.
  always_comb begin
    v_sq    = 3'd0;
    h_sq    = 3'd0;
    v_north = 1'b0;
    h_east  = 1'b0;
    casez (bus.move)
      8'b???????1: begin v_north = 1'b1; v_sq = 3'd2; h_east = 1'b1; h_sq = 3'd1; end
      8'b??????10: begin v_north = 1'b1; v_sq = 3'd2; h_east = 1'b0; h_sq = 3'd1; end
      8'b?????100: begin v_north = 1'b1; v_sq = 3'd1; h_east = 1'b0; h_sq = 3'd2; end
      8'b????1000: begin v_north = 1'b0; v_sq = 3'd1; h_east = 1'b0; h_sq = 3'd2; end
      8'b???10000: begin v_north = 1'b0; v_sq = 3'd2; h_east = 1'b0; h_sq = 3'd1; end
      8'b??100000: begin v_north = 1'b0; v_sq = 3'd2; h_east = 1'b1; h_sq = 3'd1; end
      8'b?1000000: begin v_north = 1'b0; v_sq = 3'd1; h_east = 1'b1; h_sq = 3'd2; end
      8'b10000000: begin v_north = 1'b1; v_sq = 3'd1; h_east = 1'b1; h_sq = 3'd2; end
      default:     begin v_sq = 3'd0; h_sq = 3'd0; end
    endcase
  end

  assign vert_cmd  = {OP_MOVE,    (v_north ? HDG_N : HDG_S), 1'b0, v_sq};
  assign horz_cmd  = {OP_FANFARE, (h_east  ? HDG_E : HDG_W), 1'b0, h_sq};
  assign last_move = (mv_indx_q == IDX_W'(LAST_IDX));
  assign bus.mv_indx = mv_indx_q;

  // State and move-index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mv_indx_q <= '0;
    end else begin
      state     <= state_nxt;
      mv_indx_q <= mv_indx_nxt;
    end
  end

  // Next state and outputs; tour_start beats a pending UART command.
  always_comb begin
    state_nxt        = state;
    mv_indx_nxt      = mv_indx_q;
    bus.cmd          = vert_cmd;
    bus.cmd_rdy      = 1'b0;
    bus.clr_uart_rdy = 1'b0;
    bus.resp         = RESP_LEG;
    case (state)
      IDLE: begin
        bus.cmd  = bus.uart_cmd;
        bus.resp = RESP_DONE;
        if (bus.tour_start) begin
          mv_indx_nxt = '0;
          state_nxt   = VERT;
        end else begin
          bus.cmd_rdy      = bus.uart_cmd_rdy;
          bus.clr_uart_rdy = bus.clr_cmd_rdy;
        end
      end
      VERT: begin
        if (bus.move == '0) begin
          state_nxt = IDLE;
        end else begin
          bus.cmd_rdy = 1'b1;
          if (bus.clr_cmd_rdy) state_nxt = WAIT_V;
        end
      end
      WAIT_V: begin
        if (bus.send_resp) state_nxt = HORZ;
      end
      HORZ: begin
        bus.cmd     = horz_cmd;
        bus.cmd_rdy = 1'b1;
        if (bus.clr_cmd_rdy) state_nxt = WAIT_H;
      end
      WAIT_H: begin
        if (last_move) bus.resp = RESP_DONE;
        if (bus.send_resp) begin
          if (last_move) begin
            state_nxt = IDLE;
          end else begin
            mv_indx_nxt = mv_indx_q + IDX_W'(1);
            state_nxt   = VERT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
